// File: rtl/lut_sweeper.sv
// ---------------------------------------------------------------------------
// lut_sweeper
//
// Holds an N-input Boolean function as a programmable truth table and, on
// request, walks every input vector 0..DEPTH-1 (one per clock). Each vector
// is emitted with its function value. When the walk ends, a one-cycle done
// pulse reports how many table entries were 1.
//
// Optional feature macro: LUT_SWEEP_CHECK_EN. When it is defined, each output
// value is compared against a reference table captured at start.
//
// Parameters:
//   N      number of function inputs (1..6)
//   DEPTH  2**N truth-table entries (derived, not overridable)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   lut_in     truth table; bit i is f(i), captured by load while idle
//   load       capture lut_in (idle only)
//   start      begin a sweep (idle only)
//   expected   reference table, sampled on start      (LUT_SWEEP_CHECK_EN)
//   mismatch   sticky per-sweep "value differed" flag  (LUT_SWEEP_CHECK_EN)
//   first_bad  index of first differing vector         (LUT_SWEEP_CHECK_EN)
//   x_out      current input vector (MSB = x_out[N-1])
//   s_out      function value for x_out
//   valid      x_out/s_out meaningful this cycle
//   busy       high during the cycles where vectors are emitted
//   done       one-cycle pulse after the last vector
//   ones_count number of 1 entries seen in the last completed sweep
// ---------------------------------------------------------------------------
module lut_sweeper #(
    parameter int N = 2,
    localparam int DEPTH = 2 ** N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEPTH-1:0] lut_in,
    input  logic             load,
    input  logic             start,
`ifdef LUT_SWEEP_CHECK_EN
    input  logic [DEPTH-1:0] expected,
    output logic             mismatch,
    output logic [N-1:0]     first_bad,
`endif
    output logic [N-1:0]     x_out,
    output logic             s_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [N:0]       ones_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The index never wraps, so the all-ones value is the terminal vector.
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE  = N'(1);

    state_t           state_q;
    logic [DEPTH-1:0] table_q;
    logic [N-1:0]     idx_q;
    logic [N:0]       acc_q;
    logic [N-1:0]     x_q;
    logic             s_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [N:0]       ones_q;

    logic             cur_s_d;
    logic [N-1:0]     idx_d;
    logic [N:0]       acc_d;

`ifdef LUT_SWEEP_CHECK_EN
    logic [DEPTH-1:0] expected_q;
    logic             mismatch_q;
    logic [N-1:0]     first_bad_q;
`endif

    // Table lookup for the current index plus index/accumulator increments.
    always_comb begin
        cur_s_d = table_q[idx_q];
        idx_d   = idx_q + IDX_ONE;
        acc_d   = acc_q + {{N{1'b0}}, cur_s_d};
    end

    // Sweep FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            table_q     <= {DEPTH{1'b0}};
            idx_q       <= {N{1'b0}};
            acc_q       <= {(N+1){1'b0}};
            x_q         <= {N{1'b0}};
            s_q         <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ones_q      <= {(N+1){1'b0}};
`ifdef LUT_SWEEP_CHECK_EN
            expected_q  <= {DEPTH{1'b0}};
            mismatch_q  <= 1'b0;
            first_bad_q <= {N{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // A load coinciding with start lands before the first
                    // lookup, which happens one edge later in SWEEP.
                    if (load) begin
                        table_q <= lut_in;
                    end
                    if (start) begin
                        idx_q       <= {N{1'b0}};
                        acc_q       <= {(N+1){1'b0}};
                        state_q     <= ST_SWEEP;
`ifdef LUT_SWEEP_CHECK_EN
                        expected_q  <= expected;
                        mismatch_q  <= 1'b0;
                        first_bad_q <= {N{1'b0}};
`endif
                    end
                end
                ST_SWEEP: begin
                    x_q     <= idx_q;
                    s_q     <= cur_s_d;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    acc_q   <= acc_d;
`ifdef LUT_SWEEP_CHECK_EN
                    // Only the first differing vector is recorded.
                    if (!mismatch_q && (cur_s_d != expected_q[idx_q])) begin
                        mismatch_q  <= 1'b1;
                        first_bad_q <= idx_q;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                ST_DONE: begin
                    x_q     <= {N{1'b0}};
                    s_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    ones_q  <= acc_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    x_q     <= {N{1'b0}};
                    s_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_out      = x_q;
    assign s_out      = s_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ones_count = ones_q;
`ifdef LUT_SWEEP_CHECK_EN
    assign mismatch   = mismatch_q;
    assign first_bad  = first_bad_q;
`endif

endmodule

// File: doc/lut_sweeper.md
# lut_sweeper

Parametrised successor to the team's fixed two-input gate-level function blocks. The block holds an N-input Boolean function as a programmable truth table (LUT). On request, it sweeps every input combination in order, one per clock, and emits each input vector with its function value. At the end it reports the number of true minterms. It replaces the hand-written per-function testbench loops and sits between the lab stimulus generator and the result logger.

## Interface

Parameters:
- `N`, default 2: number of function inputs. Legal range is 1..6.
- `DEPTH`, derived as 2**N: the number of truth-table entries. It is a localparam and cannot be overridden.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `lut_in`, in, DEPTH: truth table. Bit i is the function value for input vector i.
- `load`, in, 1: captures `lut_in` into the internal table. Accepted only in IDLE.
- `start`, in, 1: begins a sweep. Accepted only in IDLE.
- `x_out`, out, N: current input vector. `x_out[N-1]` is the MSB. For N=2, `x_out` = {x, y}.
- `s_out`, out, 1: function value for `x_out`.
- `valid`, out, 1: `x_out` and `s_out` are meaningful this cycle.
- `busy`, out, 1: high while in SWEEP.
- `done`, out, 1: one-cycle pulse after the last vector.
- `ones_count`, out, N+1: number of 1 entries seen in the last sweep. Ranges 0..DEPTH.

## Operation

States:
- IDLE: waits for `load` or `start`.
- SWEEP: outputs one vector per cycle.
- DONE: asserts `done` for one cycle, then returns to IDLE.

Transitions:
- IDLE with `start` → SWEEP. The index is cleared to 0 and the accumulator is cleared to 0.
- SWEEP with index == DEPTH-1 → DONE.
- DONE → IDLE unconditionally. `start` is ignored during DONE.

Each SWEEP cycle:
- `x_out` = index.
- `s_out` = table[index].
- `valid` = 1.
- The accumulator adds `s_out`. The index increments by 1.

In DONE, `ones_count` is updated with the final accumulator value. It then holds that value until the next DONE or reset.

Edge cases:
- `load` and `start` asserted together in IDLE: the load takes effect first, and the sweep uses the new table.
- `load` or `start` asserted while in SWEEP or DONE: ignored. The table is never modified mid-sweep.
- Index never wraps: DEPTH-1 is terminal. The index counter is N+1 bits wide, or N bits with explicit terminal detect.
- Arithmetic: the accumulator is N+1 bits, unsigned, with no saturation needed because the maximum is DEPTH.

Outputs outside SWEEP:
- `valid` = 0.
- `x_out` and `s_out` hold 0.

## Timing

- All outputs are registered.
- If `start` is sampled at edge k, the first `valid` cycle begins at edge k+1 with `x_out` = 0.
- The last vector is DEPTH-1, output at edge k+DEPTH.
- `done` is high from edge k+DEPTH+1 for exactly one cycle. `ones_count` is valid from the same edge.
- `busy` is high for edges k+1 .. k+DEPTH, which is exactly the cycles where `valid` is high.
- Minimum start-to-start period is DEPTH+2 cycles.
- `load` sampled at edge j makes the table available for a sweep started at edge j.

Reset values, while `reset` is high:
- State = IDLE.
- Table = 0.
- `x_out` = 0.
- `s_out` = 0.
- `valid` = 0.
- `busy` = 0.
- `done` = 0.
- `ones_count` = 0.

A reset asserted mid-sweep aborts the sweep immediately and asynchronously. No `done` pulse is produced. After release, the block waits in IDLE.

## Configuration

Macro: `LUT_SWEEP_CHECK_EN`.

When defined, the block gains:
- Input `expected` [DEPTH-1:0], sampled on `start`.
- Output `mismatch`, 1 bit, registered and sticky per sweep. It is set in any SWEEP cycle where `s_out` differs from `expected[index]`, and cleared on `start` and on reset.
- Output `first_bad` [N-1:0]: the index of the first mismatch. It holds 0 if there is no mismatch. Both outputs are final when `done` pulses.

When undefined, the ports are absent and the logic is not synthesised. All other behaviour is identical.

## Test plan

1. N=2, load `lut_in`=4'b0010 (the function s = ~x & y), then start → `s_out` sequence 0,1,0,0 for `x_out` 0,1,2,3; `done` pulses at start+5; `ones_count`=1.
2. N=2, load 4'b1111 and start in the same cycle → sweep uses the new table; `ones_count`=4; `busy` is high for exactly 4 cycles.
3. N=3, load 8'hA5, start, then pulse `load` with 8'h00 and `start` at cycle 3 of the sweep → both ignored; sweep completes with `ones_count`=4; second sweep after DONE still gives 4.
4. N=2, assert `reset` at the third `valid` cycle → all outputs 0 in the same cycle; no `done`; a fresh `start` after reset gives `ones_count`=0, since the table is cleared.
5. N=6, load all ones → 64 `valid` cycles; `ones_count`=64 (7'b1000000); `done` at start+65.
6. With `LUT_SWEEP_CHECK_EN`, N=2: table 4'b0010, `expected` 4'b0110 → `mismatch`=1, `first_bad`=2; with `expected` 4'b0010 → `mismatch`=0, `first_bad`=0.
